mem_ctrl_ram: RTL and testbench
===============================

Name: mem_ctrl_ram

Overview:
Parametrised single-port synchronous RAM with explicit read/write controls. It is the successor to the fixed 3-bit/8-entry memory, generalised in data width, depth and read latency. It adds an automatic post-reset clear sequence, a ready/valid handshake and error reporting. It sits between the datapath and the load/store control logic.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 4, address width in bits (>=1)
DEPTH, 16, number of implemented words (1 .. 2**ADDR_W)
READ_LAT, 1, read latency in cycles from sampling edge to valid data (1 or 2)

Ports:
clk  input  1  clock; all sampling on rising edge
rst_n  input  1  reset, asynchronous, active-low
mem_read_ctrl  input  1  read request
mem_write_ctrl  input  1  write request
mem_address  input  ADDR_W  word address
mem_data_write  input  DATA_W  write data
mem_ready  output  1  block accepts requests (IDLE state)
mem_data_read  output  DATA_W  read data; holds last value between reads
mem_read_valid  output  1  one-cycle pulse, mem_data_read carries new read result
mem_err  output  1  one-cycle pulse on an illegal request
init_done  output  1  high once the clear sequence has completed; stays high until next reset

Behaviour:
- Reset (rst_n=0, asynchronous): mem_ready=0, mem_data_read=0, mem_read_valid=0, mem_err=0, init_done=0. Read pipeline is flushed. Clear counter=0. State=CLEAR.
- States: CLEAR -> IDLE only. There is no other transition except reset.
- CLEAR state:
  - Each rising edge writes 0 to mem[clr_cnt], then clr_cnt++.
  - On the edge that writes location DEPTH-1, next state=IDLE and init_done=1.
  - mem_ready=1 from the cycle following that edge, i.e. after exactly DEPTH edges following reset release.
  - Requests during CLEAR are ignored silently: no write, no valid, no err.
- IDLE state (mem_ready=1): a request is sampled on each rising edge. There is no backpressure; a new request may be issued every cycle.
- Write (write=1, read=0, address<DEPTH): mem[address] <= mem_data_write at the edge. There is no response pulse.
- Read (read=1, write=0, address<DEPTH):
  - mem_data_read = mem[address], with mem_read_valid=1, exactly READ_LAT cycles after the sampling edge.
  - READ_LAT=1: registered array output. READ_LAT=2: one extra output register stage.
  - Back-to-back reads are fully pipelined; results return in request order.
- Read-after-write: a read issued on the cycle after a write to the same address returns the new data.
- Simultaneous read=1 and write=1: the write is performed and the read is dropped (no valid). mem_err pulses for 1 cycle, on the cycle after the sampling edge.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W), err pulses 1 cycle after the sampling edge:
  - Write: dropped, mem_err pulses.
  - Read: returns data 0 with mem_read_valid at the normal latency, and mem_err pulses.
  - Read+write: nothing is written, no valid, single mem_err pulse.
- Neither control asserted: no action; outputs hold, except valid/err, which return to 0.
- mem_read_valid and mem_err are never high for more than one cycle per request.
- Reset mid-operation:
  - In-flight reads are discarded; no valid is produced after reset.
  - The clear restarts from address 0 and the full memory is re-zeroed.
- Memory array is not otherwise reset. Contents are defined only via the clear sequence.

Test Plan:
1. Reset release, DEPTH=16: mem_ready=0 for 16 edges then 1; init_done rises with it. Reading all 16 addresses -> each returns 0x00 with valid.
2. READ_LAT=1: write 0xA5 to addr 3, write 0x5A to addr 4, read 3, read 4 on consecutive cycles -> valid on 2 consecutive cycles carrying 0xA5 then 0x5A, each 1 cycle after its request.
3. READ_LAT=2: same sequence -> identical data, each valid 2 cycles after its request. Write to addr 7 followed by an immediate read of addr 7 -> new data returned.
4. Simultaneous read=1, write=1 at addr 2, data 0x33 -> mem_err pulse, no valid. A subsequent read of addr 2 returns 0x33.
5. DEPTH=12, ADDR_W=4: write 0xFF to addr 13 -> mem_err pulse. Read addr 13 -> data 0x00 with valid and mem_err. Read addr 11 -> 0x00, no err.
6. Issue a read and assert rst_n=0 before its valid: no valid is produced. A write issued during the subsequent CLEAR is ignored. After ready, all locations read 0.

Source files
------------

// File: rtl/mem_ctrl_ram.sv
// mem_ctrl_ram: parametrised single-port synchronous RAM with a post-reset clear
// sequence, an IDLE ready flag, pipelined reads (latency 1 or 2) and error pulses.
module mem_ctrl_ram #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_ctrl,
  input  logic              mem_write_ctrl,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data_write,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_data_read,
  output logic              mem_read_valid,
  output logic              mem_err,
  output logic              init_done
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle_c;
  logic              in_range_c;
  logic              rd_hit_c;
  logic              err_c;
  logic              we_c;
  logic [ADDR_W-1:0] we_addr_c;
  logic [DATA_W-1:0] we_data_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              out_v_c;
  logic [DATA_W-1:0] out_d_c;

  // Request decode: clear writes take the port in CLEAR, requests only count in IDLE
  always_comb begin
    idle_c     = (state == ST_IDLE);
    in_range_c = ({1'b0, mem_address} < DEPTH_LIM);
    rd_hit_c   = idle_c & mem_read_ctrl & ~mem_write_ctrl;
    err_c      = idle_c & ((mem_read_ctrl & mem_write_ctrl) |
                           ((mem_read_ctrl | mem_write_ctrl) & ~in_range_c));
    we_c       = 1'b0;
    we_addr_c  = mem_address;
    we_data_c  = mem_data_write;
    rd_data_c  = '0;
    if (state == ST_CLEAR) begin
      we_c      = 1'b1;
      we_addr_c = clr_cnt;
      we_data_c = '0;
    end else if (mem_write_ctrl && in_range_c) begin
      we_c = 1'b1;
    end
    if (in_range_c) begin
      rd_data_c = mem[mem_address];
    end
  end

  // Storage array, deliberately without reset; contents come from the clear sequence
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[we_addr_c] <= we_data_c;
    end
  end

  // Optional extra read stage for READ_LAT == 2
  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              p_v;
      logic [DATA_W-1:0] p_d;
      // Intermediate read stage, flushed by reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_v <= 1'b0;
          p_d <= '0;
        end else begin
          p_v <= rd_hit_c;
          if (rd_hit_c) begin
            p_d <= rd_data_c;
          end
        end
      end
      assign out_v_c = p_v;
      assign out_d_c = p_d;
    end else begin : g_lat1
      assign out_v_c = rd_hit_c;
      assign out_d_c = rd_data_c;
    end
  endgenerate

  // Control FSM (CLEAR -> IDLE) with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_CLEAR;
      clr_cnt        <= '0;
      mem_ready      <= 1'b0;
      init_done      <= 1'b0;
      mem_read_valid <= 1'b0;
      mem_data_read  <= '0;
      mem_err        <= 1'b0;
    end else begin
      mem_read_valid <= out_v_c;
      mem_err        <= err_c;
      if (out_v_c) begin
        mem_data_read <= out_d_c;
      end
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state     <= ST_IDLE;
            mem_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_ram.sv
// tb_mem_ctrl_ram: directed bench over three configurations sharing one stimulus bus:
// u1 (DEPTH 16, latency 1), u2 (DEPTH 16, latency 2), u3 (DEPTH 12, latency 1).
module tb_mem_ctrl_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd, wr;
  logic [3:0] addr;
  logic [7:0] wdata;

  logic       o1_ready, o1_valid, o1_err, o1_init;
  logic [7:0] o1_data;
  logic       o2_ready, o2_valid, o2_err, o2_init;
  logic [7:0] o2_data;
  logic       o3_ready, o3_valid, o3_err, o3_init;
  logic [7:0] o3_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_ctrl_ram u1 (
    .clk(clk), .rst_n(rst_n), .mem_read_ctrl(rd), .mem_write_ctrl(wr),
    .mem_address(addr), .mem_data_write(wdata), .mem_ready(o1_ready),
    .mem_data_read(o1_data), .mem_read_valid(o1_valid), .mem_err(o1_err),
    .init_done(o1_init));

  mem_ctrl_ram #(.READ_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .mem_read_ctrl(rd), .mem_write_ctrl(wr),
    .mem_address(addr), .mem_data_write(wdata), .mem_ready(o2_ready),
    .mem_data_read(o2_data), .mem_read_valid(o2_valid), .mem_err(o2_err),
    .init_done(o2_init));

  mem_ctrl_ram #(.DEPTH(12)) u3 (
    .clk(clk), .rst_n(rst_n), .mem_read_ctrl(rd), .mem_write_ctrl(wr),
    .mem_address(addr), .mem_data_write(wdata), .mem_ready(o3_ready),
    .mem_data_read(o3_data), .mem_read_valid(o3_valid), .mem_err(o3_err),
    .init_done(o3_init));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    rd = r; wr = w; addr = a; wdata = d;
  endtask

  // Waits for ready after a reset release; optionally injects a write during CLEAR
  task automatic wait_clear(input string tag, input bit inject);
    int r1 = 0, r2 = 0, r3 = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (r1 == 0 && o1_ready) r1 = i;
      if (r2 == 0 && o2_ready) r2 = i;
      if (r3 == 0 && o3_ready) r3 = i;
      if (inject && i == 9) drive(1'b0, 1'b1, 4'd3, 8'hEE);
      if (inject && i == 10) begin
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        n_total++;
        if ({o1_err, o1_valid} !== 2'b00) $display("FAIL %s_clear_req_ignored: err/valid=%b expected 00", tag, {o1_err, o1_valid});
        else n_pass++;
      end
      if (r1 != 0 && r2 != 0 && r3 != 0) break;
    end
    n_total++;
    if (r1 != 16) $display("FAIL %s_ready16: ready after %0d edges, expected 16", tag, r1);
    else n_pass++;
    n_total++;
    if (r2 != 16) $display("FAIL %s_ready16_lat2: ready after %0d edges, expected 16", tag, r2);
    else n_pass++;
    n_total++;
    if (r3 != 12) $display("FAIL %s_ready12: ready after %0d edges, expected 12", tag, r3);
    else n_pass++;
    n_total++;
    if ({o1_init, o2_init, o3_init} !== 3'b111) $display("FAIL %s_init_done: got %b expected 111", tag, {o1_init, o2_init, o3_init});
    else n_pass++;
  endtask

  // Pipelined read of all 16 addresses, every result must be zero
  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) drive(1'b1, 1'b0, 4'(i), 8'h00);
      else drive(1'b0, 1'b0, 4'd0, 8'h00);
      step();
      if (i < 16) begin
        n_total++;
        if ({o1_valid, o1_data} !== 9'h100) $display("FAIL %s_u1_addr%0d: valid/data=%b/%h expected 1/00", tag, i, o1_valid, o1_data);
        else n_pass++;
      end
      if (i > 0) begin
        n_total++;
        if ({o2_valid, o2_data} !== 9'h100) $display("FAIL %s_u2_addr%0d: valid/data=%b/%h expected 1/00", tag, i - 1, o2_valid, o2_data);
        else n_pass++;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    repeat (3) step();
    n_total++;
    if ({o1_ready, o1_valid, o1_err, o1_init, o1_data} !== 12'h000)
      $display("FAIL reset_outputs: ready/valid/err/init/data=%b%b%b%b/%h expected 0000/00", o1_ready, o1_valid, o1_err, o1_init, o1_data);
    else n_pass++;
    n_total++;
    if ({o2_ready, o2_init, o3_ready, o3_init} !== 4'b0000) $display("FAIL reset_u2u3: got %b expected 0000", {o2_ready, o2_init, o3_ready, o3_init});
    else n_pass++;
    rst_n = 1'b1;
    wait_clear("init", 1'b0);
    read_all_zero("init_read");
  endtask

  task automatic test_read_latency();
    drive(1'b0, 1'b1, 4'd3, 8'hA5); step();
    drive(1'b0, 1'b1, 4'd4, 8'h5A); step();
    drive(1'b1, 1'b0, 4'd3, 8'h00); step();
    n_total++;
    if ({o1_valid, o1_data, o2_valid} !== {1'b1, 8'hA5, 1'b0}) $display("FAIL lat_rd3_c1: u1 %b/%h u2v %b expected 1/a5 0", o1_valid, o1_data, o2_valid);
    else n_pass++;
    drive(1'b1, 1'b0, 4'd4, 8'h00); step();
    n_total++;
    if ({o1_valid, o1_data, o2_valid, o2_data} !== {1'b1, 8'h5A, 1'b1, 8'hA5}) $display("FAIL lat_rd4_c1: u1 %b/%h u2 %b/%h expected 1/5a 1/a5", o1_valid, o1_data, o2_valid, o2_data);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 8'h00); step();
    n_total++;
    if ({o1_valid, o1_data, o2_valid, o2_data} !== {1'b0, 8'h5A, 1'b1, 8'h5A}) $display("FAIL lat_hold: u1 %b/%h u2 %b/%h expected 0/5a 1/5a", o1_valid, o1_data, o2_valid, o2_data);
    else n_pass++;
    step();
    n_total++;
    if ({o2_valid, o2_data} !== {1'b0, 8'h5A}) $display("FAIL lat2_end: u2 %b/%h expected 0/5a", o2_valid, o2_data);
    else n_pass++;
    drive(1'b0, 1'b1, 4'd7, 8'h77); step();
    drive(1'b1, 1'b0, 4'd7, 8'h00); step();
    n_total++;
    if ({o1_valid, o1_data} !== {1'b1, 8'h77}) $display("FAIL raw_u1: %b/%h expected 1/77", o1_valid, o1_data);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 8'h00); step();
    n_total++;
    if ({o1_valid, o2_valid, o2_data} !== {1'b0, 1'b1, 8'h77}) $display("FAIL raw_u2: u1v %b u2 %b/%h expected 0 1/77", o1_valid, o2_valid, o2_data);
    else n_pass++;
    step();
  endtask

  task automatic test_rw_conflict();
    drive(1'b1, 1'b1, 4'd2, 8'h33); step();
    n_total++;
    if ({o1_err, o1_valid, o3_err, o3_valid} !== 4'b1010) $display("FAIL conflict_pulse: u1 err/valid %b%b u3 %b%b expected 10 10", o1_err, o1_valid, o3_err, o3_valid);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 8'h00); step();
    n_total++;
    if ({o1_err, o1_valid, o2_valid, o2_err} !== 4'b0000) $display("FAIL conflict_after: u1 %b%b u2 v/e %b%b expected 00 00", o1_err, o1_valid, o2_valid, o2_err);
    else n_pass++;
    drive(1'b1, 1'b0, 4'd2, 8'h00); step();
    n_total++;
    if ({o1_valid, o1_data, o1_err, o3_valid, o3_data} !== {1'b1, 8'h33, 1'b0, 1'b1, 8'h33}) $display("FAIL conflict_write: u1 %b/%h e%b u3 %b/%h expected 1/33 e0 1/33", o1_valid, o1_data, o1_err, o3_valid, o3_data);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 8'h00); step();
  endtask

  task automatic test_out_of_range();
    drive(1'b0, 1'b1, 4'd13, 8'hFF); step();
    n_total++;
    if ({o3_err, o3_valid, o1_err} !== 3'b100) $display("FAIL oob_write: u3 err/valid %b%b u1 err %b expected 10 0", o3_err, o3_valid, o1_err);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 8'h00); step();
    n_total++;
    if (o3_err !== 1'b0) $display("FAIL oob_err_pulse: err %b expected 0", o3_err);
    else n_pass++;
    drive(1'b1, 1'b0, 4'd13, 8'h00); step();
    n_total++;
    if ({o3_valid, o3_data, o3_err} !== {1'b1, 8'h00, 1'b1}) $display("FAIL oob_read: u3 %b/%h err %b expected 1/00 1", o3_valid, o3_data, o3_err);
    else n_pass++;
    n_total++;
    if ({o1_valid, o1_data, o1_err} !== {1'b1, 8'hFF, 1'b0}) $display("FAIL inrange_13_u1: %b/%h err %b expected 1/ff 0", o1_valid, o1_data, o1_err);
    else n_pass++;
    drive(1'b1, 1'b0, 4'd11, 8'h00); step();
    n_total++;
    if ({o3_valid, o3_data, o3_err} !== {1'b1, 8'h00, 1'b0}) $display("FAIL read_last_u3: %b/%h err %b expected 1/00 0", o3_valid, o3_data, o3_err);
    else n_pass++;
    drive(1'b0, 1'b0, 4'd0, 8'h00); step();
    n_total++;
    if ({o3_valid, o3_err} !== 2'b00) $display("FAIL oob_idle: u3 valid/err %b%b expected 00", o3_valid, o3_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 4'd3, 8'h00); step();
    #1 rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    n_total++;
    if ({o1_valid, o2_valid, o1_ready} !== 3'b000) $display("FAIL midrst_async: valid u1/u2 %b%b ready %b expected 00 0", o1_valid, o2_valid, o1_ready);
    else n_pass++;
    step();
    n_total++;
    if ({o1_valid, o2_valid} !== 2'b00) $display("FAIL midrst_flush: valid u1/u2 %b%b expected 00", o1_valid, o2_valid);
    else n_pass++;
    step();
    rst_n = 1'b1;
    wait_clear("mid", 1'b1);
    read_all_zero("mid_read");
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_rw_conflict();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
